// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
//               Define MULDIV_EARLY_OUT_EN to end multiplies early.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            md_begin,
    input  logic            md_cancel,
    input  logic [1:0]      md_op,
    input  logic [XLEN-1:0] md_src1,
    input  logic [XLEN-1:0] md_src2,
    output logic            md_ready,
    output logic            md_busy,
    output logic            md_end,
    output logic [XLEN-1:0] md_hi,
    output logic [XLEN-1:0] md_lo,
    output logic            md_div_zero
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     src1_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   m_q;
    logic [2*XLEN-1:0]   acc_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic                dz_q;
    logic                end_q;
    logic                busy_q;
    logic                ready_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                div_zero_q;

    logic                w_is_div;
    logic                w_signed;
    logic                w_accept;
    logic                w_calc_last;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;

    assign w_is_div = op_q[1];
    assign w_signed = ~op_q[0];
    assign w_accept = md_begin & ready_q & ~md_cancel;
    assign w_a_abs  = (w_signed && src1_q[XLEN-1]) ? -src1_q : src1_q;
    assign w_b_abs  = (w_signed && b_q[XLEN-1])    ? -b_q    : b_q;

    // One iteration: shift-add multiply (b_q shifts out LSB first) or
    // restoring divide with acc_q = {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   acc_d;
    logic [2*XLEN-1:0]   m_d;
    logic [XLEN-1:0]     b_d;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;

    always_comb begin
        w_rem_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, b_q};
        acc_d    = acc_q;
        m_d      = m_q;
        b_d      = b_q;
        if (w_is_div) begin
            if (w_diff[XLEN]) begin
                acc_d = {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_d = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            if (b_q[0]) begin
                acc_d = acc_q + m_q;
            end
            m_d = {m_q[2*XLEN-2:0], 1'b0};
            b_d = {1'b0, b_q[XLEN-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign w_calc_last = (cnt_q == CNT_LAST) ||
                         (!w_is_div && (b_q[XLEN-1:1] == '0));
`else
    assign w_calc_last = (cnt_q == CNT_LAST);
`endif

    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_fix_hi;
    logic [XLEN-1:0]     w_fix_lo;

    always_comb begin
        w_prod   = neg_lo_q ? -acc_q : acc_q;
        w_fix_hi = w_prod[2*XLEN-1:XLEN];
        w_fix_lo = w_prod[XLEN-1:0];
        if (w_is_div) begin
            if (dz_q) begin
                w_fix_hi = src1_q;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                w_fix_lo = neg_lo_q ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            src1_q     <= '0;
            b_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            end_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            end_q <= 1'b0;
            if (md_cancel && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (w_accept) begin
                            op_q    <= md_op;
                            src1_q  <= md_src1;
                            b_q     <= md_src2;
                            state_q <= S_PREP;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                    S_PREP: begin
                        acc_q    <= w_is_div ? {{XLEN{1'b0}}, w_a_abs} : '0;
                        m_q      <= {{XLEN{1'b0}}, w_a_abs};
                        b_q      <= w_b_abs;
                        neg_lo_q <= w_signed & (src1_q[XLEN-1] ^ b_q[XLEN-1]);
                        neg_hi_q <= w_signed & w_is_div & src1_q[XLEN-1];
                        dz_q     <= w_is_div && (b_q == '0);
                        cnt_q    <= '0;
                        state_q  <= S_CALC;
                    end
                    S_CALC: begin
                        acc_q <= acc_d;
                        m_q   <= m_d;
                        b_q   <= b_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (w_calc_last) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        hi_q       <= w_fix_hi;
                        lo_q       <= w_fix_lo;
                        div_zero_q <= dz_q;
                        end_q      <= 1'b1;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign md_ready    = ready_q;
    assign md_busy     = busy_q;
    assign md_end      = end_q;
    assign md_hi       = hi_q;
    assign md_lo       = lo_q;
    assign md_div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            md_begin = 1'b0;
    logic            md_cancel = 1'b0;
    logic [1:0]      md_op = 2'b00;
    logic [XLEN-1:0] md_src1 = '0;
    logic [XLEN-1:0] md_src2 = '0;
    logic            md_ready;
    logic            md_busy;
    logic            md_end;
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;
    logic            md_div_zero;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .md_begin   (md_begin),
        .md_cancel  (md_cancel),
        .md_op      (md_op),
        .md_src1    (md_src1),
        .md_src2    (md_src2),
        .md_ready   (md_ready),
        .md_busy    (md_busy),
        .md_end     (md_end),
        .md_hi      (md_hi),
        .md_lo      (md_lo),
        .md_div_zero(md_div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [XLEN-1:0] b);
        int k;
        k = XLEN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [XLEN-1:0] m;
            m = (!op[0] && b[XLEN-1]) ? -b : b;
            k = 1;
            for (int i = 0; i < XLEN; i++) if (m[i]) k = i + 1;
        end
`endif
        return k + 2;
    endfunction

    // Present a start, take the accept edge, return at accept+0 (+1 time unit).
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        md_op    = op;
        md_src1  = a;
        md_src2  = b;
        md_begin = 1'b1;
        @(posedge clk); #1;
        md_begin = 1'b0;
    endtask

    // Wait for md_end from accept+0; returns in the DONE cycle.
    task automatic wait_done(input string tag, input int lat_exp,
                             input logic [XLEN-1:0] hi_exp, input logic [XLEN-1:0] lo_exp,
                             input logic dz_exp, input bit poke);
        int lat;
        int nb;
        lat = -1;
        nb  = 0;
        check({tag, " ready_low"}, 64'(md_ready), 64'd0);
        for (int i = 0; i < 100; i++) begin
            if (poke && i == 3) begin
                md_begin = 1'b1;
                md_op    = 2'b11;
                md_src1  = $urandom;
                md_src2  = $urandom;
            end
            if (poke && i == 6) md_begin = 1'b0;
            if (md_busy) nb++;
            if (md_end) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " end"},     64'(md_end),      64'd1);
        check({tag, " latency"}, 64'(lat),         64'(lat_exp));
        check({tag, " busy"},    64'(nb),          64'(lat_exp));
        check({tag, " hi"},      64'(md_hi),       64'(hi_exp));
        check({tag, " lo"},      64'(md_lo),       64'(lo_exp));
        check({tag, " dz"},      64'(md_div_zero), 64'(dz_exp));
        check({tag, " ready"},   64'(md_ready),    64'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] hi_exp, input logic [XLEN-1:0] lo_exp,
                          input logic dz_exp, input bit poke);
        issue(op, a, b);
        wait_done(tag, exp_lat(op, b), hi_exp, lo_exp, dz_exp, poke);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, 64'(md_ready),    64'd1);
        check({tag, " busy"},  64'(md_busy),     64'd0);
        check({tag, " end"},   64'(md_end),      64'd0);
        check({tag, " hi"},    64'(md_hi),       64'd0);
        check({tag, " lo"},    64'(md_lo),       64'd0);
        check({tag, " dz"},    64'(md_div_zero), 64'd0);
    endtask

    int t1;
    int nend;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("multu_3x5",   2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0);
        run_op("mult_neg2",   2'b00, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1);
        run_op("mult_7xm3",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
        run_op("multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("div_7_m2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
        run_op("divu_big_16", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0);
        run_op("divu_7_0",    2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("div_m7_0",    2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Signed overflow, then a new start issued in its DONE cycle.
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", XLEN + 2, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        t1 = cyc;
        issue(2'b11, 32'd100, 32'd7);
        wait_done("divu_b2b", XLEN + 2, 32'd2, 32'd14, 1'b0, 1'b0);
        check("b2b spacing", 64'(cyc - t1), 64'(XLEN + 3));
        @(posedge clk); #1;

        // Cancel mid-flight.
        issue(2'b01, 32'h0000_1234, 32'hFFFF_FFFF);
        repeat (10) begin @(posedge clk); #1; end
        md_cancel = 1'b1;
        @(posedge clk); #1;
        md_cancel = 1'b0;
        check("cancel busy",  64'(md_busy),  64'd0);
        check("cancel ready", 64'(md_ready), 64'd1);
        nend = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_end) nend++;
            @(posedge clk); #1;
        end
        check("cancel no_end", 64'(nend),  64'd0);
        check("cancel hi",     64'(md_hi), 64'd2);
        check("cancel lo",     64'(md_lo), 64'd14);

        // Start and cancel together: not accepted.
        md_op = 2'b01; md_src1 = 32'd3; md_src2 = 32'd5;
        md_begin  = 1'b1;
        md_cancel = 1'b1;
        @(posedge clk); #1;
        md_begin  = 1'b0;
        md_cancel = 1'b0;
        check("begin_cancel ready", 64'(md_ready), 64'd1);
        check("begin_cancel busy",  64'(md_busy),  64'd0);
        nend = 0;
        for (int i = 0; i < 40; i++) begin
            if (md_end || md_busy) nend++;
            @(posedge clk); #1;
        end
        check("begin_cancel idle", 64'(nend), 64'd0);

        // Reset in the middle of a divide, then start right away.
        issue(2'b11, 32'd1000, 32'd3);
        repeat (20) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        run_op("after_reset", 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
